box_track_ctrl: RTL and testbench

Frame-synchronous controller that generates the bounding-box coordinates consumed by the VGA overlay stage. It scans a per-pixel detection mask aligned to the active display area and accumulates the min/max x/y of hit pixels across one frame. At frame end it commits the box, or declares it lost, so the overlay coordinates never change during active display.

---
 rtl/box_track_ctrl_pkg.sv | 28 ++
 rtl/box_minmax_acc.sv | 28 ++
 rtl/box_track_ctrl.sv | 157 +++++++++++++++
 tb/tb_box_track_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/box_track_ctrl_pkg.sv
// Shared constants, coordinate type and FSM state encoding for the
// bounding-box tracking controller.
package box_track_ctrl_pkg;

  localparam int H_DISP = 1024;
  localparam int V_DISP = 768;
  localparam int CRD_W  = 11;

  typedef logic [CRD_W-1:0] coord_t;

  // Off-screen sentinel: the overlay draws nothing for this coordinate
  localparam coord_t BOX_NONE = 11'h7FF;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACCUM    = 2'd1,
    COMMIT   = 2'd2
  } state_t;

  function automatic coord_t coord_min(input coord_t a, input coord_t b);
    return (a < b) ? a : b;
  endfunction

  function automatic coord_t coord_max(input coord_t a, input coord_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/box_minmax_acc.sv
// Per-axis running min/max tracker; init clears to the empty range,
// init together with update loads the current coordinate directly.
module box_minmax_acc
  import box_track_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             init,
  input  logic             update,
  input  logic [CRD_W-1:0] coord,
  output logic [CRD_W-1:0] min_val,
  output logic [CRD_W-1:0] max_val
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_val <= BOX_NONE;
      max_val <= '0;
    end else if (init) begin
      min_val <= update ? coord : BOX_NONE;
      max_val <= update ? coord : '0;
    end else if (update) begin
      min_val <= coord_min(min_val, coord);
      max_val <= coord_max(max_val, coord);
    end
  end

endmodule

// File: rtl/box_track_ctrl.sv
// Frame-synchronous bounding-box controller: accumulates hit extents over
// one frame and commits (or drops) the box two clocks after the last pixel.
module box_track_ctrl
  import box_track_ctrl_pkg::*;
#(
  parameter int H_DISP      = box_track_ctrl_pkg::H_DISP,
  parameter int V_DISP      = box_track_ctrl_pkg::V_DISP,
  parameter int MIN_COUNT   = 64,
  parameter int HOLD_FRAMES = 8,
  parameter int CW          = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             de,
  input  logic [CRD_W-1:0] x,
  input  logic [CRD_W-1:0] y,
  input  logic             hit,
  output logic [CRD_W-1:0] x_min,
  output logic [CRD_W-1:0] x_max,
  output logic [CRD_W-1:0] y_min,
  output logic [CRD_W-1:0] y_max,
  output logic             box_valid,
  output logic             box_update
);

  localparam int MW = $clog2(HOLD_FRAMES + 1);

  localparam logic [CW-1:0]    CNT_MAX  = '1;
  localparam logic [CW-1:0]    CNT_MIN  = CW'(MIN_COUNT);
  localparam logic [MW-1:0]    MISS_SAT = MW'(HOLD_FRAMES);
  localparam logic [MW:0]      MISS_LIM = (MW+1)'(HOLD_FRAMES);
  localparam logic [CRD_W:0]   H_LIM    = (CRD_W+1)'(H_DISP);
  localparam logic [CRD_W:0]   V_LIM    = (CRD_W+1)'(V_DISP);
  localparam logic [CRD_W-1:0] X_LAST   = CRD_W'(H_DISP - 1);
  localparam logic [CRD_W-1:0] Y_LAST   = CRD_W'(V_DISP - 1);

  state_t state_q, state_d;

  logic qual, sof, eof;
  logic acc_init, acc_upd;

  logic [CRD_W-1:0] acc_xmin, acc_xmax, acc_ymin, acc_ymax;
  logic [CW-1:0]    acc_cnt;
  logic [MW-1:0]    miss_cnt;
  logic [MW:0]      miss_inc;

  logic [CRD_W-1:0] x_min_d, x_max_d, y_min_d, y_max_d;
  logic             valid_d, update_d;
  logic [MW-1:0]    miss_d;

  assign qual = de && ({1'b0, x} < H_LIM) && ({1'b0, y} < V_LIM);
  assign sof  = qual && (x == '0) && (y == '0);
  assign eof  = qual && (x == X_LAST) && (y == Y_LAST);

  // SOF restarts accumulation from idle or mid-frame, never during COMMIT
  assign acc_init = sof && (state_q != COMMIT);
  assign acc_upd  = qual && hit && (acc_init || (state_q == ACCUM));

  assign miss_inc = {1'b0, miss_cnt} + (MW+1)'(1);

  box_minmax_acc u_x_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (acc_init),
    .update  (acc_upd),
    .coord   (x),
    .min_val (acc_xmin),
    .max_val (acc_xmax)
  );

  box_minmax_acc u_y_acc (
    .clk     (clk),
    .rst_n   (rst_n),
    .init    (acc_init),
    .update  (acc_upd),
    .coord   (y),
    .min_val (acc_ymin),
    .max_val (acc_ymax)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_cnt <= '0;
    end else if (acc_init) begin
      acc_cnt <= acc_upd ? CW'(1) : '0;
    end else if (acc_upd && (acc_cnt != CNT_MAX)) begin
      acc_cnt <= acc_cnt + CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= WAIT_SOF;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_SOF: if (sof) state_d = ACCUM;
      ACCUM:    if (eof) state_d = COMMIT;
      COMMIT:   state_d = WAIT_SOF;
      default:  state_d = WAIT_SOF;
    endcase
  end

  // Commit decision: load, clear after enough consecutive misses, or hold
  always_comb begin
    x_min_d  = x_min;
    x_max_d  = x_max;
    y_min_d  = y_min;
    y_max_d  = y_max;
    valid_d  = box_valid;
    miss_d   = miss_cnt;
    update_d = 1'b0;
    if (state_q == COMMIT) begin
      update_d = 1'b1;
      if (acc_cnt >= CNT_MIN) begin
        x_min_d = acc_xmin;
        x_max_d = acc_xmax;
        y_min_d = acc_ymin;
        y_max_d = acc_ymax;
        valid_d = 1'b1;
        miss_d  = '0;
      end else if (miss_inc >= MISS_LIM) begin
        x_min_d = BOX_NONE;
        x_max_d = BOX_NONE;
        y_min_d = BOX_NONE;
        y_max_d = BOX_NONE;
        valid_d = 1'b0;
        miss_d  = MISS_SAT;
      end else begin
        miss_d = miss_inc[MW-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      x_min      <= BOX_NONE;
      x_max      <= BOX_NONE;
      y_min      <= BOX_NONE;
      y_max      <= BOX_NONE;
      box_valid  <= 1'b0;
      box_update <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      x_min      <= x_min_d;
      x_max      <= x_max_d;
      y_min      <= y_min_d;
      y_max      <= y_max_d;
      box_valid  <= valid_d;
      box_update <= update_d;
      miss_cnt   <= miss_d;
    end
  end

endmodule

// File: tb/tb_box_track_ctrl.sv
// Self-checking bench for box_track_ctrl on a reduced 32x16 raster; expected
// commits are queued at EOF and compared when box_update fires.
module tb_box_track_ctrl;

  localparam int H    = 32;
  localparam int V    = 16;
  localparam int MINC = 4;
  localparam int HOLD = 4;
  localparam logic [10:0] NONE = 11'h7FF;

  logic        clk = 1'b0;
  logic        rst_n, de, hit;
  logic [10:0] x, y;
  logic [10:0] x_min, x_max, y_min, y_max;
  logic        box_valid, box_update;

  always #5 clk = ~clk;

  box_track_ctrl #(
    .H_DISP      (H),
    .V_DISP      (V),
    .MIN_COUNT   (MINC),
    .HOLD_FRAMES (HOLD),
    .CW          (20)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .de         (de),
    .x          (x),
    .y          (y),
    .hit        (hit),
    .x_min      (x_min),
    .x_max      (x_max),
    .y_min      (y_min),
    .y_max      (y_max),
    .box_valid  (box_valid),
    .box_update (box_update)
  );

  typedef struct {
    int          rxl, rxh, ryl, ryh;
    bit          corners;
    logic [10:0] exmin, exmax, eymin, eymax;
    bit          evalid;
  } frame_vec_t;

  typedef struct {
    logic [10:0] xmin, xmax, ymin, ymax;
    bit          valid;
    int          eof_cyc;
    int          id;
  } exp_t;

  exp_t        exp_q[$];
  frame_vec_t  tbl[15];
  frame_vec_t  fv;
  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  bit          rst_n_at_edge = 1'b0;
  logic [63:0] prev_box = '0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [63:0] curBox();
    return {19'b0, x_min, x_max, y_min, y_max, box_valid};
  endfunction

  // Pops the scoreboard on every update; otherwise outputs must not move
  task automatic monitorSample();
    exp_t e;
    if (box_update === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_update", 64'(box_update), 64'd0);
      end else begin
        e = exp_q.pop_front();
        checkOutput($sformatf("c%0d_x_min", e.id), 64'(x_min), 64'(e.xmin));
        checkOutput($sformatf("c%0d_x_max", e.id), 64'(x_max), 64'(e.xmax));
        checkOutput($sformatf("c%0d_y_min", e.id), 64'(y_min), 64'(e.ymin));
        checkOutput($sformatf("c%0d_y_max", e.id), 64'(y_max), 64'(e.ymax));
        checkOutput($sformatf("c%0d_valid", e.id), 64'(box_valid), 64'(e.valid));
        checkOutput($sformatf("c%0d_latency", e.id), 64'(cyc - e.eof_cyc), 64'd2);
      end
    end else if (rst_n_at_edge) begin
      checkOutput("stable_between_commits", curBox(), prev_box);
    end
    prev_box = curBox();
  endtask

  task automatic nextCycle();
    @(negedge clk);
    monitorSample();
    @(posedge clk);
    cyc++;
    rst_n_at_edge = rst_n;
    #1;
  endtask

  task automatic drivePixel(input bit d, input int px, input int py, input bit h);
    nextCycle();
    de  = d;
    x   = 11'(px);
    y   = 11'(py);
    hit = h;
  endtask

  // Line gaps carry a de=0 fake SOF and out-of-range hits that must be ignored
  task automatic applyStimulus(input frame_vec_t f, input int row_lo, input int row_hi,
                               input bit push, input int id);
    exp_t e;
    bit   h;
    for (int r = row_lo; r <= row_hi; r++) begin
      for (int c = 0; c < H; c++) begin
        h = (c >= f.rxl && c <= f.rxh && r >= f.ryl && r <= f.ryh) ||
            (f.corners && ((c == 0 && r == 0) || (c == H-1 && r == V-1)));
        drivePixel(1'b1, c, r, h);
        if (push && c == H-1 && r == V-1) begin
          e.xmin = f.exmin; e.xmax = f.exmax;
          e.ymin = f.eymin; e.ymax = f.eymax;
          e.valid = f.evalid; e.eof_cyc = cyc; e.id = id;
          exp_q.push_back(e);
        end
      end
      drivePixel(1'b0, 0, 0, 1'b1);
      drivePixel(1'b1, H, r, 1'b1);
      drivePixel(1'b1, 1, V + 2, 1'b1);
    end
    if (row_hi == V-1) repeat (4) drivePixel(1'b0, 0, 0, 1'b0);
  endtask

  initial begin
    tbl[0]  = '{10, 19,  5,  9, 1'b0, 11'd10, 11'd19, 11'd5, 11'd9,  1'b1};
    tbl[1]  = '{ 5,  6,  5,  5, 1'b1, 11'd0,  11'd31, 11'd0, 11'd15, 1'b1};
    tbl[2]  = '{ 3,  4,  3,  3, 1'b0, 11'd0,  11'd31, 11'd0, 11'd15, 1'b1};
    tbl[3]  = '{ 3,  4,  3,  3, 1'b0, 11'd0,  11'd31, 11'd0, 11'd15, 1'b1};
    tbl[4]  = '{ 3,  4,  3,  3, 1'b0, 11'd0,  11'd31, 11'd0, 11'd15, 1'b1};
    tbl[5]  = '{ 3,  4,  3,  3, 1'b0, NONE,   NONE,   NONE,  NONE,   1'b0};
    tbl[6]  = '{ 1,  0,  1,  0, 1'b0, NONE,   NONE,   NONE,  NONE,   1'b0};
    tbl[7]  = '{20, 23,  2,  2, 1'b0, 11'd20, 11'd23, 11'd2, 11'd2,  1'b1};
    tbl[8]  = '{ 1,  3, 14, 14, 1'b0, 11'd20, 11'd23, 11'd2, 11'd2,  1'b1};
    tbl[9]  = '{ 1,  0,  1,  0, 1'b0, 11'd20, 11'd23, 11'd2, 11'd2,  1'b1};
    tbl[10] = '{ 0,  0,  0,  3, 1'b0, 11'd0,  11'd0,  11'd0, 11'd3,  1'b1};
    tbl[11] = '{ 1,  0,  1,  0, 1'b0, 11'd0,  11'd0,  11'd0, 11'd3,  1'b1};
    tbl[12] = '{ 1,  0,  1,  0, 1'b0, 11'd0,  11'd0,  11'd0, 11'd3,  1'b1};
    tbl[13] = '{ 1,  0,  1,  0, 1'b0, 11'd0,  11'd0,  11'd0, 11'd3,  1'b1};
    tbl[14] = '{ 1,  0,  1,  0, 1'b0, NONE,   NONE,   NONE,  NONE,   1'b0};

    rst_n = 1'b0; de = 1'b0; x = '0; y = '0; hit = 1'b0;
    repeat (3) nextCycle();
    rst_n = 1'b1;
    repeat (3) nextCycle();
    checkOutput("reset_x_min", 64'(x_min), 64'(NONE));
    checkOutput("reset_x_max", 64'(x_max), 64'(NONE));
    checkOutput("reset_y_min", 64'(y_min), 64'(NONE));
    checkOutput("reset_y_max", 64'(y_max), 64'(NONE));
    checkOutput("reset_valid", 64'(box_valid), 64'd0);
    checkOutput("reset_update", 64'(box_update), 64'd0);

    for (int i = 0; i < 15; i++) applyStimulus(tbl[i], 0, V-1, 1'b1, i);

    // Truncated frame: hits at x=10, then a fresh SOF restarts the frame
    fv = '{10, 10, 0, 3, 1'b0, NONE, NONE, NONE, NONE, 1'b0};
    applyStimulus(fv, 0, 3, 1'b0, 100);
    fv = '{25, 27, 4, 5, 1'b0, 11'd25, 11'd27, 11'd4, 11'd5, 1'b1};
    applyStimulus(fv, 0, V-1, 1'b1, 101);

    // One-cycle reset mid-frame; the remainder of that frame must not commit
    fv = '{8, 9, 1, 2, 1'b0, 11'd8, 11'd9, 11'd1, 11'd2, 1'b1};
    applyStimulus(fv, 0, 5, 1'b0, 102);
    nextCycle();
    rst_n = 1'b0;
    de    = 1'b0;
    nextCycle();
    checkOutput("midrst_x_min", 64'(x_min), 64'(NONE));
    checkOutput("midrst_x_max", 64'(x_max), 64'(NONE));
    checkOutput("midrst_y_min", 64'(y_min), 64'(NONE));
    checkOutput("midrst_y_max", 64'(y_max), 64'(NONE));
    checkOutput("midrst_valid", 64'(box_valid), 64'd0);
    rst_n = 1'b1;
    applyStimulus(fv, 6, V-1, 1'b0, 103);
    applyStimulus(fv, 0, V-1, 1'b1, 104);

    repeat (10) nextCycle();
    checkOutput("pending_commits", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
